// File: rtl/deflect_port_alloc.sv
// Oldest-first output-port allocator for the bufferless deflection router.
// Stage 1 merges local injection into a free input slot; stage 2 allocates ports and registers the outputs.
module deflect_port_alloc #(
   parameter int WIDTH_DATA = 32,
   parameter int WIDTH_TIME = 8,
   parameter int WIDTH_CNT  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [3:0]              in_valid,
   input  logic [4*WIDTH_DATA-1:0] in_flit,
   input  logic [4*WIDTH_TIME-1:0] in_time,
   input  logic [19:0]             in_prod,
   input  logic                    inj_valid,
   input  logic [WIDTH_DATA-1:0]   inj_flit,
   input  logic [WIDTH_TIME-1:0]   inj_time,
   input  logic [4:0]              inj_prod,
   output logic                    inj_ready,
   output logic [4:0]              out_valid,
   output logic [5*WIDTH_DATA-1:0] out_flit,
   output logic [3:0]              out_defl,
   output logic [WIDTH_CNT-1:0]    defl_cnt
);

   logic                  s1_valid_s [4];
   logic [WIDTH_DATA-1:0] s1_flit_s  [4];
   logic [WIDTH_TIME-1:0] s1_time_s  [4];
   logic [4:0]            s1_prod_s  [4];
   logic                  s1_valid_r [4];
   logic [WIDTH_DATA-1:0] s1_flit_r  [4];
   logic [WIDTH_TIME-1:0] s1_time_r  [4];
   logic [4:0]            s1_prod_r  [4];
   logic                  inj_take_s;
   logic                  inj_done_s;

   logic [1:0]            rank_s  [4];
   logic [4:0]            claim_s;
   logic [WIDTH_DATA-1:0] flit_s  [5];
   logic [3:0]            defl_s;
   logic [2:0]            ndefl_s;
   logic                  got_s;
   logic [WIDTH_CNT:0]    cnt_sum_s;
   logic [WIDTH_CNT-1:0]  cnt_next_s;

   assign inj_ready = reset & (in_valid != 4'b1111);

   // Stage-1 next state: pass valid slots through, drop injection into the lowest free slot
   always_comb begin
      inj_take_s = inj_valid & inj_ready;
      inj_done_s = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s1_valid_s[i] = in_valid[i];
         s1_flit_s[i]  = in_flit[i*WIDTH_DATA +: WIDTH_DATA];
         s1_time_s[i]  = in_time[i*WIDTH_TIME +: WIDTH_TIME];
         s1_prod_s[i]  = in_prod[i*5 +: 5];
         if (!in_valid[i] && inj_take_s && !inj_done_s) begin
            s1_valid_s[i] = 1'b1;
            s1_flit_s[i]  = inj_flit;
            s1_time_s[i]  = inj_time;
            s1_prod_s[i]  = inj_prod;
            inj_done_s    = 1'b1;
         end else begin
            inj_done_s    = inj_done_s;
         end
      end
   end

   // Stage-1 slot registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) begin
            s1_valid_r[i] <= 1'b0;
            s1_flit_r[i]  <= {WIDTH_DATA{1'b0}};
            s1_time_r[i]  <= {WIDTH_TIME{1'b0}};
            s1_prod_r[i]  <= 5'b00000;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            s1_valid_r[i] <= s1_valid_s[i];
            s1_flit_r[i]  <= s1_flit_s[i];
            s1_time_r[i]  <= s1_time_s[i];
            s1_prod_r[i]  <= s1_prod_s[i];
         end
      end
   end

   // Age rank per slot: number of valid slots that are older, ties going to the lower index
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         rank_s[i] = 2'd0;
         for (int j = 0; j < 4; j++) begin
            if (j != i && s1_valid_r[j] &&
                ((s1_time_r[j] < s1_time_r[i]) ||
                 ((s1_time_r[j] == s1_time_r[i]) && (j < i)))) begin
               rank_s[i] = rank_s[i] + 2'd1;
            end else begin
               rank_s[i] = rank_s[i];
            end
         end
      end
   end

   // Port allocation in age order: Local, then lowest productive port, else deflect to lowest free port
   always_comb begin
      claim_s = 5'b00000;
      defl_s  = 4'b0000;
      ndefl_s = 3'd0;
      got_s   = 1'b0;
      for (int p = 0; p < 5; p++) begin
         flit_s[p] = {WIDTH_DATA{1'b0}};
      end
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 4; i++) begin
            if (s1_valid_r[i] && (rank_s[i] == r[1:0])) begin
               got_s = 1'b0;
               if (s1_prod_r[i][4] && !claim_s[4]) begin
                  claim_s[4] = 1'b1;
                  flit_s[4]  = s1_flit_r[i];
                  got_s      = 1'b1;
               end else begin
                  for (int p = 0; p < 4; p++) begin
                     if (!got_s && s1_prod_r[i][p] && !claim_s[p]) begin
                        claim_s[p] = 1'b1;
                        flit_s[p]  = s1_flit_r[i];
                        got_s      = 1'b1;
                     end else begin
                        got_s      = got_s;
                     end
                  end
                  for (int p = 0; p < 4; p++) begin
                     if (!got_s && !claim_s[p]) begin
                        claim_s[p] = 1'b1;
                        flit_s[p]  = s1_flit_r[i];
                        defl_s[p]  = 1'b1;
                        ndefl_s    = ndefl_s + 3'd1;
                        got_s      = 1'b1;
                     end else begin
                        got_s      = got_s;
                     end
                  end
               end
            end else begin
               got_s = got_s;
            end
         end
      end
   end

   // Saturating deflection counter update
   always_comb begin
      cnt_sum_s = {1'b0, defl_cnt} + {{(WIDTH_CNT-2){1'b0}}, ndefl_s};
      if (cnt_sum_s[WIDTH_CNT]) begin
         cnt_next_s = {WIDTH_CNT{1'b1}};
      end else begin
         cnt_next_s = cnt_sum_s[WIDTH_CNT-1:0];
      end
   end

   // Stage-2 output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 5'b00000;
         out_flit  <= {(5*WIDTH_DATA){1'b0}};
         out_defl  <= 4'b0000;
         defl_cnt  <= {WIDTH_CNT{1'b0}};
      end else begin
         out_valid <= claim_s;
         for (int p = 0; p < 5; p++) begin
            out_flit[p*WIDTH_DATA +: WIDTH_DATA] <= flit_s[p];
         end
         out_defl  <= defl_s;
         defl_cnt  <= cnt_next_s;
      end
   end

endmodule

// File: tb/tb_deflect_port_alloc.sv
// Directed self-checking bench for deflect_port_alloc with hand-computed expectations.
module tb_deflect_port_alloc;

   localparam int WD = 32;
   localparam int WT = 8;
   localparam int WC = 16;

   logic          clk;
   logic          reset;
   logic [3:0]    in_valid;
   logic [4*WD-1:0] in_flit;
   logic [4*WT-1:0] in_time;
   logic [19:0]   in_prod;
   logic          inj_valid;
   logic [WD-1:0] inj_flit;
   logic [WT-1:0] inj_time;
   logic [4:0]    inj_prod;
   logic          inj_ready;
   logic [4:0]    out_valid;
   logic [5*WD-1:0] out_flit;
   logic [3:0]    out_defl;
   logic [WC-1:0] defl_cnt;

   int n_checks;
   int n_fail;

   deflect_port_alloc #(.WIDTH_DATA(WD), .WIDTH_TIME(WT), .WIDTH_CNT(WC)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_flit(in_flit), .in_time(in_time), .in_prod(in_prod),
      .inj_valid(inj_valid), .inj_flit(inj_flit), .inj_time(inj_time), .inj_prod(inj_prod),
      .inj_ready(inj_ready),
      .out_valid(out_valid), .out_flit(out_flit), .out_defl(out_defl), .defl_cnt(defl_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      in_valid  = 4'b0000;
      in_flit   = '0;
      in_time   = '0;
      in_prod   = '0;
      inj_valid = 1'b0;
      inj_flit  = '0;
      inj_time  = '0;
      inj_prod  = 5'b00000;
   endtask

   task automatic set_slot(input int i, input logic [WD-1:0] f, input logic [WT-1:0] t,
                           input logic [4:0] p);
      in_valid[i]         = 1'b1;
      in_flit[i*WD +: WD] = f;
      in_time[i*WT +: WT] = t;
      in_prod[i*5 +: 5]   = p;
   endtask

   function automatic logic [WD-1:0] oflit(input int p);
      return out_flit[p*WD +: WD];
   endfunction

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b0;
      clear_in();
      tick();
      tick();
      check_eq("rst_out_valid", 64'(out_valid), 64'h0);
      check_eq("rst_out_defl", 64'(out_defl), 64'h0);
      check_eq("rst_defl_cnt", 64'(defl_cnt), 64'h0);
      check_eq("rst_inj_ready", 64'(inj_ready), 64'h0);
      #2 reset = 1'b1;
      tick();

      // single flit to E
      set_slot(0, 32'hA5A5A5A5, 8'd5, 5'b00010);
      tick();
      clear_in();
      tick();
      check_eq("single_valid", 64'(out_valid), 64'h02);
      check_eq("single_flitE", 64'(oflit(1)), 64'hA5A5A5A5);
      check_eq("single_flitW_zero", 64'(oflit(0)), 64'h0);
      check_eq("single_defl", 64'(out_defl), 64'h0);
      check_eq("single_cnt", 64'(defl_cnt), 64'h0);
      tick();
      check_eq("idle_valid", 64'(out_valid), 64'h0);

      // E contention: older slot2 wins, slot0 deflected to W
      set_slot(0, 32'h0000AAAA, 8'd9, 5'b00010);
      set_slot(2, 32'h0000BBBB, 8'd3, 5'b00010);
      tick();
      clear_in();
      tick();
      check_eq("econt_valid", 64'(out_valid), 64'h03);
      check_eq("econt_flitE", 64'(oflit(1)), 64'h0000BBBB);
      check_eq("econt_flitW", 64'(oflit(0)), 64'h0000AAAA);
      check_eq("econt_defl", 64'(out_defl), 64'h1);
      check_eq("econt_cnt", 64'(defl_cnt), 64'h1);

      // ejection tie: slot1 ejects, slot3 deflected to W
      set_slot(1, 32'h0000CCCC, 8'd4, 5'b10000);
      set_slot(3, 32'h0000DDDD, 8'd4, 5'b10000);
      tick();
      clear_in();
      tick();
      check_eq("ej_valid", 64'(out_valid), 64'h11);
      check_eq("ej_flitL", 64'(oflit(4)), 64'h0000CCCC);
      check_eq("ej_flitW", 64'(oflit(0)), 64'h0000DDDD);
      check_eq("ej_defl", 64'(out_defl), 64'h1);
      check_eq("ej_cnt", 64'(defl_cnt), 64'h2);

      // second productive port taken when first is claimed
      set_slot(0, 32'h00001111, 8'd1, 5'b00010);
      set_slot(1, 32'h00002222, 8'd2, 5'b00110);
      tick();
      clear_in();
      tick();
      check_eq("prod2_valid", 64'(out_valid), 64'h06);
      check_eq("prod2_flitS", 64'(oflit(2)), 64'h00002222);
      check_eq("prod2_defl", 64'(out_defl), 64'h0);

      // injection blocked when all slots busy
      set_slot(0, 32'h10, 8'd1, 5'b00001);
      set_slot(1, 32'h11, 8'd2, 5'b00010);
      set_slot(2, 32'h12, 8'd3, 5'b00100);
      set_slot(3, 32'h13, 8'd4, 5'b01000);
      inj_valid = 1'b1;
      inj_flit  = 32'hDEAD0001;
      inj_time  = 8'd0;
      inj_prod  = 5'b10000;
      #1;
      check_eq("inj_full_ready", 64'(inj_ready), 64'h0);
      tick();
      clear_in();
      tick();
      check_eq("inj_full_valid", 64'(out_valid), 64'h0F);
      check_eq("inj_full_flitL", 64'(oflit(4)), 64'h0);

      // injection into free slot1
      set_slot(0, 32'h20, 8'd1, 5'b00001);
      set_slot(2, 32'h22, 8'd3, 5'b00100);
      set_slot(3, 32'h23, 8'd4, 5'b00010);
      inj_valid = 1'b1;
      inj_flit  = 32'hBEEF0002;
      inj_time  = 8'd2;
      inj_prod  = 5'b01000;
      #1;
      check_eq("inj_ready", 64'(inj_ready), 64'h1);
      tick();
      clear_in();
      tick();
      check_eq("inj_valid_out", 64'(out_valid), 64'h0F);
      check_eq("inj_flitN", 64'(oflit(3)), 64'hBEEF0002);
      check_eq("inj_defl", 64'(out_defl), 64'h0);
      check_eq("inj_cnt", 64'(defl_cnt), 64'h2);

      // saturation: four ejection requests per cycle, three deflected
      for (int i = 0; i < 4; i++) begin
         set_slot(i, 32'h100 + 32'(i), 8'd7, 5'b10000);
      end
      tick();
      tick();
      check_eq("sat_valid", 64'(out_valid), 64'h17);
      check_eq("sat_defl", 64'(out_defl), 64'h7);
      check_eq("sat_flitL", 64'(oflit(4)), 64'h100);
      check_eq("sat_cnt_first", 64'(defl_cnt), 64'h5);
      for (int c = 0; c < 22000; c++) begin
         tick();
      end
      check_eq("sat_cnt_max", 64'(defl_cnt), 64'hFFFF);
      tick();
      tick();
      check_eq("sat_cnt_hold", 64'(defl_cnt), 64'hFFFF);

      // reset between stage-1 capture and stage-2 output
      clear_in();
      set_slot(0, 32'h55, 8'd1, 5'b00010);
      tick();
      clear_in();
      #2 reset = 1'b0;
      #1;
      check_eq("midrst_valid", 64'(out_valid), 64'h0);
      check_eq("midrst_defl", 64'(out_defl), 64'h0);
      check_eq("midrst_flit", 64'(out_flit[63:0]), 64'h0);
      check_eq("midrst_cnt", 64'(defl_cnt), 64'h0);
      check_eq("midrst_inj_ready", 64'(inj_ready), 64'h0);
      tick();
      #2 reset = 1'b1;
      tick();
      tick();
      check_eq("post_rst_valid", 64'(out_valid), 64'h0);
      check_eq("post_rst_cnt", 64'(defl_cnt), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/deflect_port_alloc.md
Name: deflect_port_alloc

Overview:
- Output-port allocator for the bufferless deflection router. Consumes the 5-bit productive vectors produced by the per-port route computation blocks and assigns each in-flight flit exactly one output port.
- Allocation is oldest-first: the flit gets a productive port if one is free, otherwise it is deflected to a free network port.
- At most one flit ejects to Local per cycle. Local injection uses a ready/valid handshake when an input slot is free.
- Two-stage pipeline sits between the route computation stage and the output link registers.

Parameters:
- WIDTH_DATA, 32, flit payload width.
- WIDTH_TIME, 8, injection timestamp width; smaller value = older flit.
- WIDTH_CNT, 16, deflection counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  4  per-slot valid; slot i = network input i.
- in_flit  in  4*WIDTH_DATA  slot i at [i*WIDTH_DATA +: WIDTH_DATA].
- in_time  in  4*WIDTH_TIME  per-slot timestamp.
- in_prod  in  4*5  per-slot productive vector. Bit 0 W, bit 1 E, bit 2 S, bit 3 N, bit 4 Local.
- inj_valid  in  1  local injection request.
- inj_flit  in  WIDTH_DATA  injected payload.
- inj_time  in  WIDTH_TIME  injected timestamp.
- inj_prod  in  5  injected productive vector.
- inj_ready  out  1  injection accepted this cycle.
- out_valid  out  5  per-output-port valid, same bit order as prod.
- out_flit  out  5*WIDTH_DATA  per-output-port payload.
- out_defl  out  4  network output p carries a deflected flit.
- defl_cnt  out  WIDTH_CNT  saturating count of deflected flits.

Behaviour:
- Reset (reset=0, async): stage-1 and stage-2 valids cleared, out_valid=0, out_defl=0, out_flit=0, defl_cnt=0, inj_ready=0. In-flight flits are dropped. Reset mid-operation takes effect immediately; first post-reset outputs appear 2 edges after new inputs.
- inj_ready:
  - Combinational: inj_ready = reset & (in_valid != 4'b1111).
  - Independent of inj_valid.
  - Transfer occurs when inj_valid & inj_ready at a rising edge.
- Stage 1 (edge k):
  - Registers all valid in_* slots unchanged.
  - An accepted injection fills the lowest-index slot whose in_valid=0, taking inj_flit, inj_time and inj_prod.
  - Invalid slots register valid=0.
- Stage 2 (edge k+1): combinational allocation over stage-1 slots, registered at edge k+1. Latency is 2 edges from input to out_*.
- Allocation order:
  - Valid slots are processed by ascending timestamp (older first).
  - Equal timestamps are broken by lower slot index first.
  - Timestamps are compared unsigned with no wrap handling.
- Per flit, in order:
  - (a) If prod[4]=1 and Local is unclaimed: assign Local.
  - (b) Else, if any unclaimed network port p (0..3) has prod[p]=1: assign the lowest such p.
  - (c) Else: assign the lowest-index unclaimed network port and mark it deflected (out_defl[p]=1).
  - A flit with only prod[4] set that loses Local takes path (c).
  - At most 4 flits and 4 network ports exist, so a port always exists in (c). No flit is ever dropped.
  - A flit with prod=0 is allocated via (c) and counted as deflected. Route computation never produces prod=0; the bench must not drive it.
- Outputs:
  - out_valid[p]=1 iff port p was claimed; out_flit for unclaimed ports holds 0.
  - out_defl[4] does not exist; ejection is never a deflection.
- defl_cnt: increments at edge k+1 by the number of deflected flits (0..4) and saturates at 2^WIDTH_CNT-1.
- Conservation: popcount(out_valid) equals the number of valid stage-1 slots, every cycle.

Test Plan:
- Single flit: slot0 valid, prod=5'b00010, time=5, flit=0xA5A5A5A5. Two edges later: out_valid=5'b00010, out_flit[E]=0xA5A5A5A5, out_defl=0, defl_cnt=0.
- E contention: slot0 time=9 prod=00010; slot2 time=3 prod=00010. Slot2 gets E. Slot0 is deflected to W: out_valid=00011, out_defl=0001, defl_cnt=1.
- Ejection contention: slot1 time=4 prod=10000; slot3 time=4 prod=10000. Slot1 ejects (tie goes to the lower index). Slot3 goes to W with out_defl[0]=1.
- Injection:
  - in_valid=1111 with inj_valid=1 -> inj_ready=0 and no injected flit appears.
  - in_valid=1101 -> inj_ready=1. The injected flit occupies slot1, and its prod=01000 yields out_valid[3]=1 two edges later.
- Saturation: 4 flits per cycle all prod=10000 (3 deflections/cycle) for 22000 cycles -> defl_cnt=0xFFFF and holds there.
- Reset mid-flight: drive flits, then assert reset between edges k and k+1. Outputs go to 0 immediately (async), nothing appears after release, and defl_cnt=0.
